// File: rtl/conf_bus_master.sv
`timescale 1ns/1ps
// Byte-stream to configuration-bus initiator: decodes write/read commands, drives the
// adr/wdt/val write strobe, captures rdt and returns it as a response byte stream.
module conf_bus_master #(
    parameter int DW_MA = 8,
    parameter int DW_MD = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [7:0]       cmd_dat,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    output logic [7:0]       rsp_dat,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [DW_MA-1:0] adr,
    output logic [DW_MD-1:0] wdt,
    output logic             val,
    input  logic [DW_MD-1:0] rdt,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam int         NB    = DW_MD / 8;
    localparam logic [2:0] LAST  = 3'(NB - 1);
    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_RADR  = 3'd4,
        S_RCAP  = 3'd5,
        S_RSEND = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             wr_r;
    logic [2:0]       cnt_r;
    logic [DW_MA-1:0] adr_r;
    logic [DW_MD-1:0] wdt_r;
    logic [DW_MD-1:0] shf_r;
    logic             val_r;
    logic             rsp_vld_r;
    logic             busy_r;
    logic [7:0]       err_r;
    logic             rdy_state_s;
    logic             last_s;

    // Ready is gated by reset so it reads low while rstb is held and high right after release.
    assign rdy_state_s = (state_r == S_IDLE) || (state_r == S_ADDR) || (state_r == S_WDATA);
    assign cmd_rdy     = rstb & rdy_state_s;
    assign last_s      = (cnt_r == LAST);

    assign rsp_dat = shf_r[DW_MD-1 -: 8];
    assign rsp_vld = rsp_vld_r;
    assign adr     = adr_r;
    assign wdt     = wdt_r;
    assign val     = val_r;
    assign busy    = busy_r;
    assign err_cnt = err_r;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_vld && ((cmd_dat == OP_WR) || (cmd_dat == OP_RD))) state_s = S_ADDR;
                else                                                       state_s = S_IDLE;
            end
            S_ADDR: begin
                if (cmd_vld) state_s = wr_r ? S_WDATA : S_RADR;
                else         state_s = S_ADDR;
            end
            S_WDATA: begin
                if (cmd_vld && last_s) state_s = S_WRITE;
                else                   state_s = S_WDATA;
            end
            S_WRITE: state_s = S_IDLE;
            S_RADR:  state_s = S_RCAP;
            S_RCAP:  state_s = S_RSEND;
            S_RSEND: begin
                if (rsp_rdy && last_s) state_s = S_IDLE;
                else                   state_s = S_RSEND;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register, registered strobes and datapath loads.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r   <= S_IDLE;
            wr_r      <= 1'b0;
            cnt_r     <= 3'd0;
            adr_r     <= '0;
            wdt_r     <= '0;
            shf_r     <= '0;
            val_r     <= 1'b0;
            rsp_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 8'd0;
        end else begin
            state_r   <= state_s;
            val_r     <= (state_s == S_WRITE);
            rsp_vld_r <= (state_s == S_RSEND);
            busy_r    <= (state_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    cnt_r <= 3'd0;
                    if (cmd_vld) begin
                        if (cmd_dat == OP_WR)      wr_r  <= 1'b1;
                        else if (cmd_dat == OP_RD) wr_r  <= 1'b0;
                        else if (err_r != 8'hFF)   err_r <= err_r + 8'd1;
                    end
                end
                S_ADDR: begin
                    if (cmd_vld) adr_r <= cmd_dat[DW_MA-1:0];
                end
                S_WDATA: begin
                    if (cmd_vld) begin
                        wdt_r <= DW_MD'({wdt_r, cmd_dat});
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_RCAP: begin
                    shf_r <= rdt;
                    cnt_r <= 3'd0;
                end
                S_RSEND: begin
                    if (rsp_rdy) begin
                        shf_r <= DW_MD'({shf_r, 8'h00});
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conf_bus_master.sv
`timescale 1ns/1ps
// Scoreboard bench for conf_bus_master: randomized command traffic against a reference
// register-file model, plus reset, backpressure, illegal-opcode and address-mask scenarios.
module tb_conf_bus_master;

    logic        clk = 1'b0;
    logic        rstb;
    logic [7:0]  cmd_dat;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  rsp_dat;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [7:0]  adr;
    logic [15:0] wdt;
    logic        val;
    logic [15:0] rdt;
    logic        busy;
    logic [7:0]  err_cnt;

    logic [7:0]  cmd_dat4;
    logic        cmd_vld4;
    logic        cmd_rdy4;
    logic [7:0]  rsp_dat4;
    logic        rsp_vld4;
    logic        rsp_rdy4;
    logic [3:0]  adr4;
    logic [15:0] wdt4;
    logic        val4;
    logic [15:0] rdt4;
    logic        busy4;
    logic [7:0]  err_cnt4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int rsp_cnt = 0;
    int val4_cnt = 0;
    int exp_err = 0;
    logic rdy_force = 1'b0;
    logic rdy_rand = 1'b0;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [23:0] wr_q [$];
    logic [7:0]  rsp_q [$];

    conf_bus_master #(.DW_MA(8), .DW_MD(16)) u_dut (
        .clk(clk), .rstb(rstb), .cmd_dat(cmd_dat), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .rsp_dat(rsp_dat), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .adr(adr), .wdt(wdt),
        .val(val), .rdt(rdt), .busy(busy), .err_cnt(err_cnt)
    );

    conf_bus_master #(.DW_MA(4), .DW_MD(16)) u_dut4 (
        .clk(clk), .rstb(rstb), .cmd_dat(cmd_dat4), .cmd_vld(cmd_vld4), .cmd_rdy(cmd_rdy4),
        .rsp_dat(rsp_dat4), .rsp_vld(rsp_vld4), .rsp_rdy(rsp_rdy4), .adr(adr4), .wdt(wdt4),
        .val(val4), .rdt(rdt4), .busy(busy4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Configuration memory: registered read one cycle after adr, write on val.
    initial begin
        rdt = 16'h0000;
        forever begin
            @(posedge clk);
            rdt = mem[adr];
            if (val) mem[adr] = wdt;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        rsp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rdy_force) rsp_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write strobe or response byte.
    initial begin
        logic p_vld, p_rdy, p_val;
        logic [7:0] p_dat;
        p_vld = 1'b0; p_rdy = 1'b0; p_val = 1'b0; p_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                p_vld = 1'b0; p_rdy = 1'b0; p_val = 1'b0;
            end else begin
                if (val) begin
                    chk("val_expected", 32'(wr_q.size() != 0), 32'd1);
                    if (wr_q.size() != 0) chk("wr_adr_wdt", {8'h00, adr, wdt}, {8'h00, wr_q.pop_front()});
                    chk("val_latency", cyc, last_acc_cyc);
                    chk("val_one_cycle", 32'(p_val), 32'd0);
                end
                if (rsp_vld && !p_vld) chk("rsp_latency", cyc, last_acc_cyc + 2);
                if (rsp_vld) begin
                    chk("rsp_cmd_rdy", 32'(cmd_rdy), 32'd0);
                    chk("rsp_busy", 32'(busy), 32'd1);
                end
                if (rsp_vld && p_vld && !p_rdy) chk("rsp_hold", 32'(rsp_dat), 32'(p_dat));
                if (rsp_vld && rsp_rdy) begin
                    chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                    if (rsp_q.size() != 0) chk("rsp_dat", 32'(rsp_dat), 32'(rsp_q.pop_front()));
                    rsp_cnt++;
                end
                if (val4) begin
                    val4_cnt++;
                    chk("mask_adr", 32'(adr4), 32'h7);
                    chk("mask_wdt", 32'(wdt4), 32'h0001);
                end
                p_vld = rsp_vld; p_rdy = rsp_rdy; p_val = val; p_dat = rsp_dat;
            end
        end
    end

    task automatic send_byte(input logic sel, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        if (sel) begin cmd_vld4 = 1'b1; cmd_dat4 = b; end
        else     begin cmd_vld  = 1'b1; cmd_dat  = b; end
        n = 0;
        while (!(sel ? cmd_rdy4 : cmd_rdy) && n < 200) begin @(posedge clk); #1; n++; end
        chk("cmd_accept_timeout", 32'(n >= 200), 32'd0);
        if (n < 200) begin
            @(posedge clk);
            #1;
            last_acc_cyc = cyc;
        end
        cmd_vld = 1'b0; cmd_vld4 = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int gmax, output int op_cyc);
        wr_q.push_back({a, d});
        ref_mem[a] = d;
        send_byte(1'b0, 8'h01, $urandom_range(0, gmax));
        op_cyc = last_acc_cyc;
        send_byte(1'b0, a, $urandom_range(0, gmax));
        send_byte(1'b0, d[15:8], $urandom_range(0, gmax));
        send_byte(1'b0, d[7:0], $urandom_range(0, gmax));
    endtask

    task automatic do_read(input logic [7:0] a, input int gmax);
        logic [15:0] d;
        d = ref_mem[a];
        rsp_q.push_back(d[15:8]);
        rsp_q.push_back(d[7:0]);
        send_byte(1'b0, 8'h02, $urandom_range(0, gmax));
        send_byte(1'b0, a, $urandom_range(0, gmax));
    endtask

    task automatic do_illegal(input int gmax);
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (b == 8'h01 || b == 8'h02) b = 8'($urandom_range(0, 255));
        send_byte(1'b0, b, $urandom_range(0, gmax));
        exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wr_q.size() != 0 || rsp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", 32'(n >= 2000), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({tag, "_rsp_dat"}, 32'(rsp_dat), 32'd0);
        chk({tag, "_adr"}, 32'(adr), 32'd0);
        chk({tag, "_wdt"}, 32'(wdt), 32'd0);
        chk({tag, "_val"}, 32'(val), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int c1, c2, n, r0;
        rstb = 1'b0; cmd_vld = 1'b0; cmd_dat = 8'h00;
        cmd_vld4 = 1'b0; cmd_dat4 = 8'h00; rsp_rdy4 = 1'b1; rdt4 = 16'h0000;
        for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; ref_mem[i] = 16'h0000; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk_reset_vals("rst");
        rstb = 1'b1;
        #1;
        chk("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk_reset_vals("post_rst");

        // Back-to-back writes, then read back the first.
        do_write(8'h03, 16'hBEEF, 0, c1);
        do_write(8'h04, 16'h1357, 0, c2);
        chk("b2b_period", c2 - c1, 5);
        do_read(8'h03, 0);
        drain();

        // Response backpressure for five cycles.
        rdy_force = 1'b1;
        rsp_rdy = 1'b0;
        do_read(8'h03, 0);
        n = 0;
        while (!rsp_vld && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_vld_timeout", 32'(n >= 20), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_msb", 32'(rsp_dat), 32'hBE);
        chk("bp_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        r0 = rsp_cnt;
        rsp_rdy = 1'b1;
        rdy_force = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("bp_nb_bytes", rsp_cnt - r0, 2);

        // Illegal opcodes, then saturation.
        send_byte(1'b0, 8'h00, 0);
        send_byte(1'b0, 8'h7F, 0);
        send_byte(1'b0, 8'hFF, 0);
        exp_err = 3;
        @(posedge clk); #1;
        chk("illegal_err3", 32'(err_cnt), 32'd3);
        chk("illegal_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 256; i++) do_illegal(0);
        @(posedge clk); #1;
        chk("illegal_sat", 32'(err_cnt), 32'(exp_err));

        // Reset in the middle of the data bytes of a write.
        send_byte(1'b0, 8'h01, 0);
        send_byte(1'b0, 8'h05, 0);
        send_byte(1'b0, 8'h12, 0);
        rstb = 1'b0;
        #1;
        chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        exp_err = 0;
        #1;
        chk("midrst_rel_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk_reset_vals("midrst_rel");
        repeat (4) @(posedge clk);
        #1;
        do_write(8'h05, 16'h1234, 0, c1);
        drain();

        // Randomized traffic with command gaps and response backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 6)      do_write(8'($urandom_range(0, 255)), 16'($urandom), 3, c1);
            else if (k < 9) do_read(8'($urandom_range(0, 255)), 3);
            else            do_illegal(3);
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("rand_idle", 32'(busy), 32'd0);

        // Address masking on the 4-bit-address instance.
        send_byte(1'b1, 8'h01, 0);
        send_byte(1'b1, 8'hF7, 0);
        send_byte(1'b1, 8'h00, 0);
        send_byte(1'b1, 8'h01, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mask_val_count", val4_cnt, 1);
        chk("mask_no_rsp", 32'(rsp_vld4), 32'(rsp_dat4 != 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_bus_master.md
# conf_bus_master

Byte-stream to configuration-bus initiator for the video IP register blocks. Accepts write and read commands as a valid/ready byte stream from a host-side bridge, drives the single-cycle `adr`/`wdt`/`val` write strobe into a configuration memory block, and captures that block's registered `rdt`. Read data is returned on a valid/ready response byte stream. It sits between the host link and the configuration memory of each video IP.

## Interface
- `DW_MA`, 8: config address width; must be ≤ 8.
- `DW_MD`, 16: config data width; must be a multiple of 8 and ≤ 32.
- `NB`, `DW_MD/8`: data bytes per word (derived localparam, not overridable).

- `clk`  in  1  clock; all logic is on the rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `cmd_dat`  in  8  command stream byte.
- `cmd_vld`  in  1  `cmd_dat` valid.
- `cmd_rdy`  out  1  block accepts `cmd_dat`; a byte transfers when `cmd_vld && cmd_rdy`.
- `rsp_dat`  out  8  response byte.
- `rsp_vld`  out  1  `rsp_dat` valid.
- `rsp_rdy`  in  1  downstream accepts `rsp_dat`.
- `adr`  out  DW_MA  config address (registered).
- `wdt`  out  DW_MD  config write data (registered).
- `val`  out  1  one-cycle write strobe.
- `rdt`  in  DW_MD  config read data; the memory registers it one cycle after `adr`.
- `busy`  out  1  high in every state except IDLE.
- `err_cnt`  out  8  saturating count of illegal opcodes.

## Operation
- Command format:
  - byte 0 is the opcode: 0x01 = write, 0x02 = read.
  - byte 1 is the address; the low DW_MA bits are used and the upper bits are ignored.
  - a write carries NB further data bytes, MSB first.
- FSM states: IDLE, ADDR, WDATA, WRITE, RADR, RCAP, RSEND.
- IDLE, `cmd_rdy`=1:
  - 0x01 goes to ADDR with the write flag set; 0x02 goes to ADDR with the read flag set.
  - Any other opcode is consumed, `err_cnt` is incremented (saturates at 0xFF), and the FSM stays in IDLE.
- ADDR, `cmd_rdy`=1: on accept, `adr` <= byte[DW_MA-1:0]. Next state is WDATA for a write or RADR for a read.
- WDATA, `cmd_rdy`=1:
  - Shifts bytes into `wdt` MSB first; a byte counter runs 0..NB-1.
  - On accepting byte NB-1, goes to WRITE.
- WRITE, `cmd_rdy`=0: `val`=1 for exactly this one cycle, with `adr`/`wdt` stable. Next state is IDLE.
- RADR, `cmd_rdy`=0: `adr` is held one cycle so the memory registers `rdt`. Next state is RCAP.
- RCAP, `cmd_rdy`=0: captures `rdt` into the response shift register. Next state is RSEND.
- RSEND, `cmd_rdy`=0:
  - `rsp_vld`=1 and `rsp_dat` = current MSB byte.
  - On `rsp_vld && rsp_rdy`, shift left 8 and advance the counter.
  - After byte NB-1 is accepted, go to IDLE.
- `rsp_dat` is held stable while `rsp_vld && !rsp_rdy`.
- `adr` and `wdt` keep their last values outside their load states; they change only on accepted bytes.
- Stalls: `cmd_vld`=0 in IDLE, ADDR or WDATA holds the state indefinitely, with no timeout.

## Timing
- Reset values: `cmd_rdy`=0 during reset and 1 in the first cycle after reset; `rsp_vld`=0, `rsp_dat`=0, `adr`=0, `wdt`=0, `val`=0, `busy`=0, `err_cnt`=0; FSM in IDLE.
- Write latency: `val` is high in the cycle after the final data byte is accepted. The next opcode is accepted no earlier than the cycle after `val`.
- Back-to-back writes: NB+3 cycles per write, i.e. 5 cycles for `DW_MD`=16.
- Read latency: the address byte is accepted at edge N. RADR is cycle N+1, RCAP is N+2, and `rsp_vld` rises in cycle N+3.
- Reset mid-operation: the partial command is discarded, the response is dropped, and no `val` is issued after reset is released.
- `cmd_vld` and `rsp_rdy` do not interact: the command stream is not read while in RSEND.

## Test plan
- **Reset:** assert `rstb`=0 mid-WDATA, then release.
  - All outputs are at reset values and `val` never pulses.
  - A subsequent write 01 05 12 34 gives `val` with `adr`=0x05 and `wdt`=0x1234.
- **Write then read:** stream 01 03 BE EF back-to-back, then 02 03, against a conf_mem model.
  - `val` is high one cycle, 1 cycle after byte EF.
  - `rsp` returns BE then EF, with `rsp_vld` rising 3 cycles after the address byte.
- **Response backpressure:** on a read, hold `rsp_rdy`=0 for 5 cycles.
  - `rsp_dat` is held at the MSB byte, `cmd_rdy`=0, and `busy`=1.
  - After release, exactly NB bytes are delivered.
- **Illegal opcodes:** send 0x00, 0x7F and 0xFF.
  - `err_cnt`=3 and there is no bus activity.
  - Send 256 more illegal bytes: `err_cnt` saturates at 0xFF.
- **Command gaps:** `cmd_vld` is gapped randomly between bytes of a write; `wdt`/`adr` are correct and there is exactly one `val`.
- **Address masking:** with `DW_MA`=4, send 01 F7 00 01; `adr`=0x7.
